// File: rtl/uart_pkg.sv
// Shared UART constants and FSM encoding.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int UART_FRAME_BITS = 10;
   localparam int UART_DATA_BITS  = 8;
   localparam int UART_BAUD_TICKS = 28781;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmit queue.
// Producer drives data/valid, queue answers ready.
interface uart_tx_if;

   logic [uart_pkg::UART_DATA_BITS-1:0] data;
   logic                                valid;
   logic                                ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting to be framed.
// Head is visible on rdata while not empty.
module uart_tx_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte queue.
// tx is registered, so it trails the FSM state by one cycle.
module uart_tx
   import uart_pkg::*;
#(
   parameter  int BAUD_TICKS = UART_BAUD_TICKS,
   parameter  int FIFO_DEPTH = 4,
   localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   uart_tx_if.slave      host,
   output logic          tx,
   output logic          busy,
   output logic [CW-1:0] fifo_count
);

   localparam int TW = (BAUD_TICKS > 2) ? $clog2(BAUD_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_TICKS - 1);

   uart_state_t                state;
   uart_state_t                state_nxt;
   logic [TW-1:0]              tick_cnt;
   logic [2:0]                 bit_cnt;
   logic [UART_DATA_BITS-1:0]  shift;
   logic [UART_DATA_BITS-1:0]  head;
   logic                       bit_end;
   logic                       pop;
   logic                       tx_nxt;
   logic                       fifo_full;
   logic                       fifo_empty;

   assign host.ready = ~fifo_full;
   assign bit_end    = (tick_cnt == TICK_LAST);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (host.valid),
      .wdata   (host.data),
      .pop     (pop),
      .rdata   (head),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (!fifo_empty)
               state_nxt = START;
         end
         START: begin
            if (bit_end)
               state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && bit_cnt == 3'd7)
               state_nxt = STOP;
         end
         STOP: begin
            if (bit_end)
               state_nxt = fifo_empty ? IDLE : START;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Back-to-back frames: the next byte pops on the last stop tick.
   always_comb begin
      busy   = 1'b1;
      tx_nxt = 1'b1;
      pop    = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            pop  = ~fifo_empty;
         end
         START: tx_nxt = 1'b0;
         DATA:  tx_nxt = shift[0];
         STOP:  pop    = bit_end & ~fifo_empty;
         default: begin
            busy   = 1'b0;
            tx_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx       <= 1'b1;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         tx <= tx_nxt;
         if (pop) begin
            shift    <= head;
            tick_cnt <= '0;
            bit_cnt  <= '0;
         end else if (state != IDLE) begin
            if (bit_end) begin
               tick_cnt <= '0;
               if (state == DATA) begin
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end else begin
               tick_cnt <= tick_cnt + TW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame vectors, queueing,
// reset abort and a behavioural receiver loopback.
module tb_uart_tx;

   logic       clk;
   logic       reset_n;
   logic       tx0;
   logic       busy0;
   logic [2:0] cnt0;
   logic       tx1;
   logic       busy1;
   logic [2:0] cnt1;

   int errors = 0;
   int checks = 0;

   logic [7:0] rxq [$];

   typedef struct {
      logic [7:0] d;
      logic [9:0] fr;
   } vec_t;

   vec_t tbl [5];

   uart_tx_if if0 ();
   uart_tx_if if1 ();

   uart_tx #(.BAUD_TICKS(4), .FIFO_DEPTH(4)) dut0 (
      .clk        (clk),
      .reset_n    (reset_n),
      .host       (if0),
      .tx         (tx0),
      .busy       (busy0),
      .fifo_count (cnt0)
   );

   uart_tx #(.BAUD_TICKS(16), .FIFO_DEPTH(4)) dut1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .host       (if1),
      .tx         (tx1),
      .busy       (busy1),
      .fifo_count (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic line(input int which);
      return (which != 0) ? tx1 : tx0;
   endfunction

   task automatic check_frame(input logic [9:0] fr, input string nm);
      for (int b = 0; b < 10; b++) begin
         logic [3:0] s;
         for (int c = 0; c < 4; c++) begin
            step();
            s[c] = tx0;
         end
         chk($sformatf("%s bit%0d", nm, b), int'(s), fr[b] ? 15 : 0);
      end
   endtask

   task automatic run_frame(input logic [7:0] d, input logic [9:0] fr,
                            input string nm);
      if0.valid = 1'b1;
      if0.data  = d;
      step();
      if0.valid = 1'b0;
      if0.data  = ~d;
      chk({nm, " push tx"}, int'(tx0), 1);
      chk({nm, " push cnt"}, int'(cnt0), 1);
      step();
      chk({nm, " pop tx"}, int'(tx0), 1);
      chk({nm, " pop busy"}, int'(busy0), 1);
      chk({nm, " pop cnt"}, int'(cnt0), 0);
      check_frame(fr, nm);
      chk({nm, " end busy"}, int'(busy0), 0);
   endtask

   task automatic rx_frames(input int which, input int baud, input int n);
      for (int k = 0; k < n; k++) begin
         logic [7:0] b;
         int         w;
         w = 0;
         while (line(which) !== 1'b0 && w < 2000) begin
            step();
            w++;
         end
         chk($sformatf("rx%0d start seen", which), int'(w < 2000), 1);
         if (w >= 2000)
            return;
         repeat (baud / 2) step();
         chk($sformatf("rx%0d start bit", which), int'(line(which)), 0);
         for (int i = 0; i < 8; i++) begin
            repeat (baud) step();
            b[i] = line(which);
         end
         repeat (baud) step();
         chk($sformatf("rx%0d stop bit", which), int'(line(which)), 1);
         rxq.push_back(b);
      end
   endtask

   initial begin
      int         bc [6];
      int         br [6];
      logic [7:0] burst_exp [5];
      logic [7:0] lb_exp [3];
      logic       bad;

      tbl[0] = '{8'hA5, 10'b1101001010};
      tbl[1] = '{8'h00, 10'b1000000000};
      tbl[2] = '{8'hFF, 10'b1111111110};
      tbl[3] = '{8'h3C, 10'b1001111000};
      tbl[4] = '{8'h81, 10'b1100000010};
      bc = '{1, 1, 2, 3, 4, 4};
      br = '{1, 1, 1, 1, 0, 0};
      burst_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      lb_exp = '{8'h3C, 8'h81, 8'h7E};

      reset_n   = 1'b0;
      if0.valid = 1'b0;
      if0.data  = '0;
      if1.valid = 1'b0;
      if1.data  = '0;
      #12;
      chk("reset tx", int'(tx0), 1);
      chk("reset busy", int'(busy0), 0);
      chk("reset cnt", int'(cnt0), 0);
      chk("reset ready", int'(if0.ready), 1);
      step();
      reset_n = 1'b1;
      step();
      step();

      for (int v = 0; v < 5; v++)
         run_frame(tbl[v].d, tbl[v].fr, $sformatf("vec%0d", v));

      // Two bytes in consecutive cycles: second waits in queue.
      if0.valid = 1'b1;
      if0.data  = 8'h00;
      step();
      if0.data = 8'hFF;
      step();
      if0.valid = 1'b0;
      chk("b2b cnt", int'(cnt0), 1);
      chk("b2b tx idle", int'(tx0), 1);
      check_frame(10'b1000000000, "b2b f0");
      chk("b2b gap busy", int'(busy0), 1);
      check_frame(10'b1111111110, "b2b f1");
      chk("b2b end busy", int'(busy0), 0);
      step();

      rxq.delete();
      fork
         rx_frames(0, 4, 5);
         begin
            if0.valid = 1'b1;
            if0.data  = 8'd1;
            chk("burst ready0", int'(if0.ready), 1);
            for (int k = 0; k < 6; k++) begin
               step();
               chk($sformatf("burst cnt%0d", k + 1), int'(cnt0), bc[k]);
               chk($sformatf("burst rdy%0d", k + 1), int'(if0.ready), br[k]);
               if0.data = 8'(k + 2);
            end
            if0.valid = 1'b0;
         end
      join
      chk("burst rx count", rxq.size(), 5);
      for (int k = 0; k < 5 && k < rxq.size(); k++)
         chk($sformatf("burst byte%0d", k), int'(rxq[k]), int'(burst_exp[k]));
      repeat (4) step();
      bad = 1'b0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (tx0 !== 1'b1 || busy0 !== 1'b0)
            bad = 1'b1;
      end
      chk("burst byte6 dropped", int'(bad), 0);

      // Abort in data bit 3 (frame bit 4) with two bytes queued.
      if0.valid = 1'b1;
      if0.data  = 8'h00;
      step();
      if0.data = 8'h22;
      step();
      if0.data = 8'h33;
      step();
      if0.valid = 1'b0;
      chk("abort cnt pre", int'(cnt0), 2);
      chk("abort tx start", int'(tx0), 0);
      repeat (17) step();
      chk("abort tx pre", int'(tx0), 0);
      reset_n = 1'b0;
      #1;
      chk("abort tx", int'(tx0), 1);
      chk("abort cnt", int'(cnt0), 0);
      chk("abort busy", int'(busy0), 0);
      chk("abort ready", int'(if0.ready), 1);
      step();
      step();
      reset_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (tx0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0)
            bad = 1'b1;
      end
      chk("abort no resume", int'(bad), 0);

      reset_n = 1'b0;
      step();
      reset_n   = 1'b1;
      if0.valid = 1'b1;
      if0.data  = 8'hA5;
      step();
      if0.valid = 1'b0;
      chk("first push cnt", int'(cnt0), 1);
      step();
      chk("first push busy", int'(busy0), 1);
      check_frame(10'b1101001010, "first push");
      step();

      rxq.delete();
      fork
         rx_frames(1, 16, 3);
         begin
            if1.valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
               if1.data = lb_exp[k];
               step();
            end
            if1.valid = 1'b0;
         end
      join
      chk("loop rx count", rxq.size(), 3);
      for (int k = 0; k < 3 && k < rxq.size(); k++)
         chk($sformatf("loop byte%0d", k), int'(rxq[k]), int'(lb_exp[k]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BAUD_TICKS, default 28781: clk cycles per serial bit; legal range >= 2.
REQ-002 Parameter FIFO_DEPTH, default 4: entries in the transmit queue; power of two, >= 2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 data  input  8  byte to transmit, qualified by valid.
REQ-006 valid  input  1  producer offers data this cycle.
REQ-007 ready  output  1  queue can accept a byte this cycle.
REQ-008 tx  output  1  serial line: idle high, 8N1, LSB first; driven directly from a flop.
REQ-009 busy  output  1  a frame is being shifted out.
REQ-010 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the frame in flight.

Function
REQ-011 A push SHALL occur on every cycle with valid=1 and ready=1; data is captured that edge.
REQ-012 ready SHALL be 1 when fifo_count < FIFO_DEPTH; it is combinational from fifo_count only, never from valid.
REQ-013 valid=1 with ready=0 SHALL be ignored: no push, no corruption, no error flag.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP; busy=1 in every state except IDLE.
REQ-015 In IDLE with fifo_count>0, the head SHALL pop into the shift register that edge; START is entered and tx=0 from the next cycle.
REQ-016 Latency: a push into an empty queue while in IDLE SHALL cause tx to fall exactly 2 cycles after the push edge.
REQ-017 Each bit (start, 8 data, stop) SHALL hold tx for exactly BAUD_TICKS cycles, so a frame is 10*BAUD_TICKS cycles.
REQ-018 The bit counter SHALL count 0..7 in DATA, shift LSB first, and wrap only on the DATA->STOP transition.
REQ-019 STOP SHALL drive tx=1; on its last cycle, if fifo_count>0, the next byte SHALL pop and START follows with no idle cycle; otherwise return to IDLE.
REQ-020 A simultaneous push and pop SHALL leave fifo_count unchanged; push while full-with-pop is still refused because ready reflects the pre-pop count.
REQ-021 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; the FIFO preserves order.
REQ-022 data changes while a byte is in flight SHALL NOT affect the current frame.

Reset
REQ-023 On reset_n=0, tx=1, busy=0, fifo_count=0, ready=1, FSM=IDLE, and counters and pointers are cleared, all asynchronously.
REQ-024 Reset asserted mid-frame SHALL abort the frame with tx=1 immediately, discard queued bytes, and not resume after release.
REQ-025 The first push SHALL be accepted on the first clk edge after reset_n deasserts.

Structure
REQ-026 Shared package uart_pkg SHALL hold the FSM state enum, UART_FRAME_BITS=10, UART_DATA_BITS=8, and the default BAUD_TICKS, so the receiver uses the same values.
REQ-027 The queue SHALL be a separate sub-module uart_tx_fifo (sync FIFO, push/pop/count); the baud counter and FSM stay in uart_tx.

Verification (BAUD_TICKS=4, FIFO_DEPTH=4 unless stated)
REQ-028 Push 0xA5 while idle -> tx samples per bit 0,1,0,1,0,0,1,0,1,1; falls 2 cycles after push; busy high 40 cycles.
REQ-029 Push 0x00 then 0xFF back-to-back -> two contiguous 40-cycle frames, stop bit of first followed immediately by start of second.
REQ-030 Hold valid for 6 cycles with data 1..6 while idle -> bytes 1..5 accepted (1 pops at once, 4 queued); ready=0 when fifo_count=4; byte 6 dropped; output order 1..5.
REQ-031 Assert reset_n=0 at bit 4 of a frame with 2 bytes queued -> tx=1 in the same cycle, fifo_count=0, no further frames after release.
REQ-032 Loopback into the team receiver with BAUD_TICKS=16, sending 0x3C, 0x81, 0x7E -> receiver pulses valid three times with the same bytes in order.
